// File: rtl/alu_multiciclo_if.sv
// Bus between the control unit and alu_multiciclo: request fields, status and registered results.
// Handshake: start is taken only while busy=0 and captures operacao/operA/operB/Cin on that edge;
// done pulses for exactly one cycle when result, result_hi and the flags update, and they hold until the next done.
interface alu_multiciclo_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       operacao;
    logic [WIDTH-1:0] operA;
    logic [WIDTH-1:0] operB;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             N;
    logic             Z;
    logic             C;
    logic             B;
    logic             V;

    modport master (
        output start, operacao, operA, operB, Cin,
        input  busy, done, result, result_hi, N, Z, C, B, V
    );

    modport slave (
        input  start, operacao, operA, operB, Cin,
        output busy, done, result, result_hi, N, Z, C, B, V
    );
endinterface

// File: rtl/alu_multiciclo.sv
// Registered Ahmes-compatible ALU with N/Z/C/B/V flags; MUL (shift-add) and DIV (restoring)
// iterate WIDTH cycles and return a double-width result in result/result_hi.
module alu_multiciclo #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_multiciclo_if.slave   bus,
    output logic              dbg_state_o
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADIC = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_OU   = 4'b0011;
    localparam logic [3:0] OP_E    = 4'b0100;
    localparam logic [3:0] OP_NAO  = 4'b0101;
    localparam logic [3:0] OP_DLE  = 4'b0110;
    localparam logic [3:0] OP_DLD  = 4'b0111;
    localparam logic [3:0] OP_DAE  = 4'b1000;
    localparam logic [3:0] OP_DAD  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;

    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] res_q, res_d, res_hi_q, res_hi_d;
    logic             fn_q, fn_d, fz_q, fz_d, fc_q, fc_d, fb_q, fb_d, fv_q, fv_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   add_ext, sub_ext;
    logic [WIDTH-1:0] sc_res, sc_hi;
    logic             sc_c, sc_b, sc_v;
    logic             start_iter;

    assign add_ext    = {1'b0, bus.operA} + {1'b0, bus.operB};
    assign sub_ext    = {1'b0, bus.operA} - {1'b0, bus.operB};
    assign start_iter = (bus.operacao == OP_MUL) ||
                        ((bus.operacao == OP_DIV) && (bus.operB != '0));

    always_comb begin
        sc_res = '0;
        sc_hi  = '0;
        sc_c   = 1'b0;
        sc_b   = 1'b0;
        sc_v   = 1'b0;
        case (bus.operacao)
            OP_ADIC: begin
                sc_res = add_ext[WIDTH-1:0];
                sc_c   = add_ext[WIDTH];
                sc_v   = (bus.operA[WIDTH-1] == bus.operB[WIDTH-1]) &&
                         (add_ext[WIDTH-1] != bus.operA[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sub_ext[WIDTH-1:0];
                sc_b   = sub_ext[WIDTH];
                sc_v   = (bus.operA[WIDTH-1] != bus.operB[WIDTH-1]) &&
                         (sub_ext[WIDTH-1] != bus.operA[WIDTH-1]);
            end
            OP_OU:  sc_res = bus.operA | bus.operB;
            OP_E:   sc_res = bus.operA & bus.operB;
            OP_NAO: sc_res = ~bus.operA;
            OP_DLE: begin
                sc_res = {bus.operA[WIDTH-2:0], bus.Cin};
                sc_c   = bus.operA[WIDTH-1];
            end
            OP_DLD: begin
                sc_res = {bus.Cin, bus.operA[WIDTH-1:1]};
                sc_c   = bus.operA[0];
            end
            OP_DAE: begin
                sc_res = {bus.operA[WIDTH-2:0], 1'b0};
                sc_c   = bus.operA[WIDTH-1];
            end
            OP_DAD: begin
                sc_res = {1'b0, bus.operA[WIDTH-1:1]};
                sc_c   = bus.operA[0];
            end
            // Only reaches here for a zero divisor; the iterative path covers the rest.
            OP_DIV: begin
                sc_res = '1;
                sc_hi  = bus.operA;
                sc_v   = 1'b1;
            end
            default: ;
        endcase
    end

    // MUL: {hi,lo} starts as {0,B}; add A into hi when lo[0] is set, then shift right.
    logic [WIDTH-1:0] mul_addend, mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   mul_sum;
    assign mul_addend = lo_q[0] ? opa_q : '0;
    assign mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
    assign mul_hi_n   = mul_sum[WIDTH:1];
    assign mul_lo_n   = {mul_sum[0], lo_q[WIDTH-1:1]};

    // DIV: hi is the partial remainder, lo shifts the dividend out and the quotient in.
    logic [WIDTH:0]   div_ext;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_n, div_quo_n, it_hi, it_lo;
    assign div_ext   = {hi_q, lo_q[WIDTH-1]};
    assign div_ge    = div_ext >= {1'b0, opb_q};
    assign div_rem_n = div_ge ? (div_ext[WIDTH-1:0] - opb_q) : div_ext[WIDTH-1:0];
    assign div_quo_n = {lo_q[WIDTH-2:0], div_ge};
    assign it_hi     = is_div_q ? div_rem_n : mul_hi_n;
    assign it_lo     = is_div_q ? div_quo_n : mul_lo_n;

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        fn_d     = fn_q;
        fz_d     = fz_q;
        fc_d     = fc_q;
        fb_d     = fb_q;
        fv_d     = fv_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (start_iter) begin
                        state_d  = CALC;
                        opa_d    = bus.operA;
                        opb_d    = bus.operB;
                        is_div_d = (bus.operacao == OP_DIV);
                        hi_d     = '0;
                        lo_d     = (bus.operacao == OP_DIV) ? bus.operA : bus.operB;
                        cnt_d    = '0;
                    end else begin
                        res_d    = sc_res;
                        res_hi_d = sc_hi;
                        fn_d     = sc_res[WIDTH-1];
                        fz_d     = (sc_res == '0);
                        fc_d     = sc_c;
                        fb_d     = sc_b;
                        fv_d     = sc_v;
                        done_d   = 1'b1;
                    end
                end
            end
            CALC: begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    res_d    = it_lo;
                    res_hi_d = it_hi;
                    fn_d     = it_lo[WIDTH-1];
                    fz_d     = (it_lo == '0);
                    fc_d     = !is_div_q && (it_hi != '0);
                    fb_d     = 1'b0;
                    fv_d     = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            res_q    <= '0;
            res_hi_q <= '0;
            fn_q     <= 1'b0;
            fz_q     <= 1'b0;
            fc_q     <= 1'b0;
            fb_q     <= 1'b0;
            fv_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            fn_q     <= fn_d;
            fz_q     <= fz_d;
            fc_q     <= fc_d;
            fb_q     <= fb_d;
            fv_q     <= fv_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy      = (state_q == CALC);
    assign bus.done      = done_q;
    assign bus.result    = res_q;
    assign bus.result_hi = res_hi_q;
    assign bus.N         = fn_q;
    assign bus.Z         = fz_q;
    assign bus.C         = fc_q;
    assign bus.B         = fb_q;
    assign bus.V         = fv_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed bench for alu_multiciclo at WIDTH=8 and WIDTH=16: drivers push expectations,
// per-instance monitors pop and compare whenever done is seen.
module tb_alu_multiciclo;
  logic clk = 1'b0;
  logic rst_n;
  logic dbg8, dbg16;
  int cyc = 0;
  int total = 0;
  int bad = 0;

  logic [20:0] exp8_q[$];
  int          cyc8_q[$];
  logic [36:0] exp16_q[$];
  int          cyc16_q[$];

  alu_multiciclo_if #(.WIDTH(8))  if8();
  alu_multiciclo_if #(.WIDTH(16)) if16();

  alu_multiciclo #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8), .dbg_state_o(dbg8)
  );
  alu_multiciclo #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16), .dbg_state_o(dbg16)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard monitors
  logic [20:0] m8_e;
  int          m8_c;
  always @(negedge clk) begin
    if (if8.done === 1'b1) begin
      if (exp8_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w8_unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        m8_e = exp8_q.pop_front();
        m8_c = cyc8_q.pop_front();
        check("w8_outputs", {if8.result, if8.result_hi, if8.N, if8.Z, if8.C, if8.B, if8.V}, m8_e);
        check("w8_done_cycle", cyc, m8_c);
      end
    end
  end

  logic [36:0] m16_e;
  int          m16_c;
  always @(negedge clk) begin
    if (if16.done === 1'b1) begin
      if (exp16_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL w16_unexpected_done: got done=1 at cycle %0d, required no done", cyc);
      end else begin
        m16_e = exp16_q.pop_front();
        m16_c = cyc16_q.pop_front();
        check("w16_outputs", {if16.result, if16.result_hi, if16.N, if16.Z, if16.C, if16.B, if16.V}, m16_e);
        check("w16_done_cycle", cyc, m16_c);
      end
    end
  end

  // drivers; flags are given as {N,Z,C,B,V}
  task automatic op8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] er, input logic [7:0] eh, input logic [4:0] ef, input int lat);
    @(negedge clk);
    if8.operacao = op;
    if8.operA    = a;
    if8.operB    = b;
    if8.Cin      = cin;
    if8.start    = 1'b1;
    exp8_q.push_back({er, eh, ef});
    cyc8_q.push_back(cyc + 1 + lat);
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    if8.operA = ~a;
    if8.operB = ~b;
    check("w8_busy_after_start", if8.busy, (lat > 0));
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk);
      #1;
      check("w8_busy_iter", if8.busy, (i < lat));
    end
  endtask

  task automatic op16(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [15:0] er, input logic [15:0] eh, input logic [4:0] ef, input int lat);
    @(negedge clk);
    if16.operacao = op;
    if16.operA    = a;
    if16.operB    = b;
    if16.Cin      = cin;
    if16.start    = 1'b1;
    exp16_q.push_back({er, eh, ef});
    cyc16_q.push_back(cyc + 1 + lat);
    @(posedge clk);
    #1;
    if16.start = 1'b0;
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk);
      #1;
      check("w16_busy_iter", if16.busy, (i < lat));
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    if8.start = 1'b0;  if8.operacao = 4'd0;  if8.operA = '0;  if8.operB = '0;  if8.Cin = 1'b0;
    if16.start = 1'b0; if16.operacao = 4'd0; if16.operA = '0; if16.operB = '0; if16.Cin = 1'b0;
    #12;
    check("w8_reset_outputs", {if8.busy, if8.done, if8.result, if8.result_hi, if8.N, if8.Z, if8.C, if8.B, if8.V, dbg8}, 0);
    check("w16_reset_outputs", {if16.busy, if16.done, if16.result, if16.result_hi, if16.N, if16.Z, if16.C, if16.B, if16.V}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single-cycle ops, issued back-to-back
    op8(4'b0001, 8'd255, 8'd1,   1'b0, 8'd0,   8'd0, 5'b01100, 0);
    op8(4'b0010, 8'd0,   8'd1,   1'b0, 8'd255, 8'd0, 5'b10010, 0);
    op8(4'b0110, 8'd129, 8'd0,   1'b1, 8'd3,   8'd0, 5'b00100, 0);
    op8(4'b0111, 8'd129, 8'd0,   1'b1, 8'd192, 8'd0, 5'b10100, 0);
    op8(4'b1001, 8'd129, 8'd0,   1'b1, 8'd64,  8'd0, 5'b00100, 0);
    op8(4'b1000, 8'd129, 8'd0,   1'b1, 8'd2,   8'd0, 5'b00100, 0);
    op8(4'b0011, 8'h0F,  8'hF0,  1'b0, 8'hFF,  8'd0, 5'b10000, 0);
    op8(4'b0100, 8'h0F,  8'hF0,  1'b0, 8'h00,  8'd0, 5'b01000, 0);
    op8(4'b0101, 8'h55,  8'h00,  1'b0, 8'hAA,  8'd0, 5'b10000, 0);
    op8(4'b0001, 8'd100, 8'd27,  1'b1, 8'd127, 8'd0, 5'b00000, 0);
    op8(4'b0001, 8'd100, 8'd50,  1'b0, 8'd150, 8'd0, 5'b10001, 0);
    op8(4'b0010, 8'd5,   8'd3,   1'b0, 8'd2,   8'd0, 5'b00000, 0);
    op8(4'b0010, 8'h80,  8'd1,   1'b0, 8'h7F,  8'd0, 5'b00001, 0);
    op8(4'b1111, 8'd5,   8'd3,   1'b1, 8'd0,   8'd0, 5'b01000, 0);
    op8(4'b0000, 8'd9,   8'd9,   1'b1, 8'd0,   8'd0, 5'b01000, 0);

    // iterative ops
    op8(4'b1010, 8'd200, 8'd3,   1'b0, 8'd88,  8'd2,   5'b00100, 8);
    op8(4'b1011, 8'd200, 8'd7,   1'b0, 8'd28,  8'd4,   5'b00000, 8);
    op8(4'b1011, 8'd77,  8'd0,   1'b0, 8'd255, 8'd77,  5'b10001, 0);
    op8(4'b1010, 8'd255, 8'd255, 1'b0, 8'd1,   8'hFE,  5'b00100, 8);
    op8(4'b1010, 8'd15,  8'd17,  1'b0, 8'd255, 8'd0,   5'b10000, 8);
    op8(4'b1011, 8'd5,   8'd9,   1'b0, 8'd0,   8'd5,   5'b01000, 8);
    op8(4'b0001, 8'd1,   8'd1,   1'b0, 8'd2,   8'd0,   5'b00000, 0);

    // start during MUL is ignored; outputs hold while busy
    @(negedge clk);
    if8.operacao = 4'b1010; if8.operA = 8'd200; if8.operB = 8'd3; if8.Cin = 1'b0; if8.start = 1'b1;
    exp8_q.push_back({8'd88, 8'd2, 5'b00100});
    cyc8_q.push_back(cyc + 1 + 8);
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    if8.operacao = 4'b0001; if8.operA = 8'd1; if8.operB = 8'd1; if8.start = 1'b1;
    check("w8_hold_while_busy", {if8.busy, if8.result, if8.N, if8.Z, if8.C}, {1'b1, 8'd2, 3'b000});
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    n = 0;
    while (if8.busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("w8_mul_finishes", if8.busy, 0);
    repeat (3) @(negedge clk);

    // reset mid-MUL aborts
    @(negedge clk);
    if8.operacao = 4'b1010; if8.operA = 8'd255; if8.operB = 8'd255; if8.start = 1'b1;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("w8_abort_outputs", {if8.busy, if8.done, if8.result, if8.result_hi, if8.N, if8.Z, if8.C, if8.B, if8.V, dbg8}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    op8(4'b0001, 8'd10, 8'd20, 1'b0, 8'd30, 8'd0, 5'b00000, 0);

    // WIDTH=16
    op16(4'b0001, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h0000, 5'b10001, 0);
    op16(4'b1111, 16'h1234, 16'h5678, 1'b1, 16'h0000, 16'h0000, 5'b01000, 0);
    op16(4'b1010, 16'h1234, 16'h0100, 1'b0, 16'h3400, 16'h0012, 5'b00100, 16);
    op16(4'b1011, 16'hFFFF, 16'h0010, 1'b0, 16'h0FFF, 16'h000F, 5'b00000, 16);

    repeat (3) @(negedge clk);
    check("w8_queue_drained", exp8_q.size(), 0);
    check("w16_queue_drained", exp16_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
